// File: rtl/estimate_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | estimate_seq : job sequencer for the 32-lane binary-CNN estimate datapath  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module estimate_seq #(
  parameter int KERN_N = 9,
  parameter int POOL_N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] cfg_base,
  input  logic [15:0] cfg_norm,
  input  logic [15:0] cfg_init,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [2:0]  com,
  output logic [15:0] addr,
  output logic [31:0] data,
  input  logic [31:0] activ,
  output logic [31:0] out_activ,
  output logic        busy,
  output logic        done
);

  localparam int c_KW = (KERN_N > 1) ? $clog2(KERN_N) : 1;
  localparam int c_PW = (POOL_N > 1) ? $clog2(POOL_N) : 1;

  localparam logic [c_KW-1:0] c_K_LAST = c_KW'(KERN_N - 1);
  localparam logic [c_PW-1:0] c_P_LAST = c_PW'(POOL_N - 1);
  localparam logic [1:0]      c_W_LAST = 2'd2;

  localparam logic [2:0] c_COM_INI  = 3'd0;
  localparam logic [2:0] c_COM_ACC  = 3'd1;
  localparam logic [2:0] c_COM_POOL = 3'd2;
  localparam logic [2:0] c_COM_NORM = 3'd3;
  localparam logic [2:0] c_COM_ACTV = 3'd4;
  localparam logic [2:0] c_COM_NOP  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INI  = 3'd1,
    S_ACC  = 3'd2,
    S_POOL = 3'd3,
    S_NORM = 3'd4,
    S_ACTV = 3'd5,
    S_WAIT = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_KW-1:0] r_k, w_k_nxt;
  logic [c_PW-1:0] r_p, w_p_nxt;
  logic [1:0]      r_w, w_w_nxt;
  logic [15:0]     r_base, r_norm, r_init;
  logic [31:0]     r_out_activ;

  assign out_activ = r_out_activ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_p         <= '0;
      r_w         <= '0;
      r_base      <= '0;
      r_norm      <= '0;
      r_init      <= '0;
      r_out_activ <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_p     <= w_p_nxt;
      r_w     <= w_w_nxt;
      // Configuration is frozen for the whole job at acceptance.
      if (r_state == S_IDLE && start) begin
        r_base <= cfg_base;
        r_norm <= cfg_norm;
        r_init <= cfg_init;
      end
      // Last WAIT cycle is the first one where the ACTV result is visible.
      if (r_state == S_WAIT && r_w == c_W_LAST) begin
        r_out_activ <= activ;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_p_nxt     = r_p;
    w_w_nxt     = r_w;
    com         = c_COM_NOP;
    addr        = '0;
    data        = '0;
    in_ready    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = S_INI;
        end
      end

      S_INI: begin
        com         = c_COM_INI;
        data        = {16'h0, r_init};
        w_k_nxt     = '0;
        w_p_nxt     = '0;
        w_state_nxt = S_ACC;
      end

      S_ACC: begin
        in_ready = 1'b1;
        // Address stays on the beat during a stall so the param RAM keeps pace.
        addr     = r_base + 16'(r_k);
        if (in_valid) begin
          com  = c_COM_ACC;
          data = in_data;
          if (r_k == c_K_LAST) begin
            w_k_nxt     = '0;
            w_state_nxt = S_POOL;
          end else begin
            w_k_nxt = r_k + c_KW'(1);
          end
        end
      end

      S_POOL: begin
        com  = c_COM_POOL;
        data = {16'h0, r_init};
        if (r_p == c_P_LAST) begin
          w_state_nxt = S_NORM;
        end else begin
          w_p_nxt     = r_p + c_PW'(1);
          w_k_nxt     = '0;
          w_state_nxt = S_ACC;
        end
      end

      S_NORM: begin
        com         = c_COM_NORM;
        addr        = r_norm;
        w_state_nxt = S_ACTV;
      end

      S_ACTV: begin
        com         = c_COM_ACTV;
        w_w_nxt     = '0;
        w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (r_w == c_W_LAST) begin
          w_w_nxt     = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_w_nxt = r_w + 2'd1;
        end
      end

      S_DONE: begin
        busy        = 1'b0;
        done        = 1'b1;
        w_p_nxt     = '0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_estimate_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_estimate_seq : directed scoreboard bench with a behavioral datapath     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_estimate_seq;

  typedef struct {
    logic [2:0]  com;
    logic [15:0] addr;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic        rdy;
    logic        valid;
    logic        chk_data;
    int          beat;
  } step_t;

  logic        clk = 1'b0;
  logic        rst_n, start, sel, in_valid;
  logic [15:0] cfg_base, cfg_norm, cfg_init;
  logic [31:0] in_data;
  logic        start0, start1;
  logic        in_ready0, in_ready1, busy0, busy1, done0, done1;
  logic [2:0]  com0, com1;
  logic [15:0] addr0, addr1;
  logic [31:0] data0, data1, out_activ0, out_activ1;
  logic [31:0] activ0 = '0;
  logic [31:0] activ1;

  logic        ob_rdy, ob_busy, ob_done;
  logic [2:0]  ob_com;
  logic [15:0] ob_addr;
  logic [31:0] ob_data, ob_oa;

  step_t       sched[$];
  logic [31:0] exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] cur_base, cur_norm, cur_init;
  int          cur_seed;

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign activ1 = 32'hC0FF_EE01;

  estimate_seq #(.KERN_N(9), .POOL_N(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cfg_base(cfg_base), .cfg_norm(cfg_norm),
    .cfg_init(cfg_init), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .com(com0), .addr(addr0), .data(data0), .activ(activ0), .out_activ(out_activ0),
    .busy(busy0), .done(done0)
  );

  estimate_seq #(.KERN_N(1), .POOL_N(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cfg_base(cfg_base), .cfg_norm(cfg_norm),
    .cfg_init(cfg_init), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .com(com1), .addr(addr1), .data(data1), .activ(activ1), .out_activ(out_activ1),
    .busy(busy1), .done(done1)
  );

  always_comb begin
    ob_com  = sel ? com1 : com0;
    ob_addr = sel ? addr1 : addr0;
    ob_data = sel ? data1 : data0;
    ob_rdy  = sel ? in_ready1 : in_ready0;
    ob_busy = sel ? busy1 : busy0;
    ob_done = sel ? done1 : done0;
    ob_oa   = sel ? out_activ1 : out_activ0;
  end

  function automatic logic [31:0] feat(input int seed, input int j);
    logic [31:0] x;
    x = 32'(seed * 1000 + j + 1) * 32'h9E37_79B9;
    return x ^ (x >> 13);
  endfunction

  function automatic logic [31:0] prm(input logic [15:0] a);
    return {a ^ 16'hA5C3, ~a + 16'h1357};
  endfunction

  function automatic logic [31:0] est(input int kn, input int pn, input logic [15:0] b,
                                      input logic [15:0] n, input logic [15:0] i, input int seed);
    logic [31:0] acc, pool, nv;
    acc  = {16'h0, i};
    pool = '0;
    for (int p = 0; p < pn; p++) begin
      for (int k = 0; k < kn; k++)
        acc = acc + 32'($countones(~(feat(seed, p * kn + k) ^ prm(b + 16'(k)))));
      if (acc > pool) pool = acc;
      acc = {16'h0, i};
    end
    nv = pool - prm(n);
    return {nv[15:0], nv[31:16]} ^ nv;
  endfunction

  // Datapath model: one input register stage (param RAM read in parallel), one core stage, output register.
  logic [2:0]  m_c1 = 3'd7;
  logic [31:0] m_d1 = '0, m_p1 = '0, m_acc = '0, m_pool = '0, m_norm = '0, m_act = '0;
  always @(posedge clk) begin
    m_c1   <= com0;
    m_d1   <= data0;
    m_p1   <= prm(addr0);
    case (m_c1)
      3'd0: begin m_acc <= m_d1; m_pool <= '0; end
      3'd1: m_acc <= m_acc + 32'($countones(~(m_d1 ^ m_p1)));
      3'd2: begin m_pool <= (m_acc > m_pool) ? m_acc : m_pool; m_acc <= m_d1; end
      3'd3: m_norm <= m_pool - m_p1;
      3'd4: m_act <= {m_norm[15:0], m_norm[31:16]} ^ m_norm;
      default: ;
    endcase
    activ0 <= m_act;
  end

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic step_t mk(input logic [2:0] c, input logic [15:0] a, input logic [31:0] d,
                               input logic b, input logic dn, input logic r, input logic v,
                               input logic cd, input int bt);
    step_t s;
    s.com = c; s.addr = a; s.data = d; s.busy = b; s.done = dn;
    s.rdy = r; s.valid = v; s.chk_data = cd; s.beat = bt;
    return s;
  endfunction

  function automatic step_t idle_step();
    return mk(3'd7, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
  endfunction

  task automatic build(input int kn, input int pn, input logic [15:0] b, input logic [15:0] n,
                       input logic [15:0] i, input int seed, input int st_beat, input int st_len);
    cur_base = b; cur_norm = n; cur_init = i; cur_seed = seed;
    sched.push_back(idle_step());
    sched.push_back(mk(3'd0, 16'h0, {16'h0, i}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0));
    for (int p = 0; p < pn; p++) begin
      for (int k = 0; k < kn; k++) begin
        if (p * kn + k == st_beat)
          for (int s = 0; s < st_len; s++)
            sched.push_back(mk(3'd7, b + 16'(k), 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, p * kn + k));
        sched.push_back(mk(3'd1, b + 16'(k), feat(seed, p * kn + k), 1'b1, 1'b0, 1'b1, 1'b1,
                           1'b1, p * kn + k));
      end
      sched.push_back(mk(3'd2, 16'h0, {16'h0, i}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0));
    end
    sched.push_back(mk(3'd3, n, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0));
    sched.push_back(mk(3'd4, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0));
    for (int w = 0; w < 3; w++)
      sched.push_back(mk(3'd7, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0));
    sched.push_back(mk(3'd7, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0));
    sched.push_back(idle_step());
    sched.push_back(idle_step());
  endtask

  // Plays the schedule cycle by cycle; cycle 0 carries the start pulse.
  task automatic run(input logic s, input int chg_cyc, input int pc1, input int pc2, input int abort_cyc);
    step_t r;
    int    c;
    c   = 0;
    sel = s;
    while (sched.size() > 0) begin
      r = sched.pop_front();
      @(posedge clk); #1;
      start    = (c == 0) || (c == pc1) || (c == pc2);
      cfg_base = (chg_cyc >= 0 && c >= chg_cyc) ? ~cur_base : cur_base;
      cfg_norm = cur_norm;
      cfg_init = cur_init;
      in_valid = r.valid;
      in_data  = feat(cur_seed, r.beat);
      rst_n    = (c != abort_cyc);
      @(negedge clk);
      chk("com", c, 32'(ob_com), 32'(r.com));
      chk("addr", c, 32'(ob_addr), 32'(r.addr));
      if (r.chk_data) chk("data", c, ob_data, r.data);
      chk("busy", c, 32'(ob_busy), 32'(r.busy));
      chk("done", c, 32'(ob_done), 32'(r.done));
      chk("in_ready", c, 32'(ob_rdy), 32'(r.rdy));
      if (ob_done && exp_q.size() > 0) chk("out_activ", c, ob_oa, exp_q.pop_front());
      c++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_base = '0; cfg_norm = '0; cfg_init = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      chk("rst_com", d, 32'(ob_com), 32'd7);
      chk("rst_addr", d, 32'(ob_addr), 32'd0);
      chk("rst_data", d, ob_data, 32'd0);
      chk("rst_busy", d, 32'(ob_busy), 32'd0);
      chk("rst_done", d, 32'(ob_done), 32'd0);
      chk("rst_rdy", d, 32'(ob_rdy), 32'd0);
      chk("rst_oa", d, ob_oa, 32'd0);
    end

    // Plain job, in_valid held high.
    build(9, 4, 16'h0100, 16'h0040, 16'h0123, 1, -1, 0);
    exp_q.push_back(est(9, 4, 16'h0100, 16'h0040, 16'h0123, 1));
    run(1'b0, -1, -1, -1, -1);

    // Beat addresses wrap through 16'hFFFF.
    build(9, 4, 16'hFFFC, 16'hBEEF, 16'h0007, 2, -1, 0);
    exp_q.push_back(est(9, 4, 16'hFFFC, 16'hBEEF, 16'h0007, 2));
    run(1'b0, -1, -1, -1, -1);

    // Five-cycle stall at position 2 beat 3; result equals the first job.
    build(9, 4, 16'h0100, 16'h0040, 16'h0123, 1, 21, 5);
    exp_q.push_back(est(9, 4, 16'h0100, 16'h0040, 16'h0123, 1));
    run(1'b0, -1, -1, -1, -1);

    // Base changed mid-job and start pulsed while busy and in DONE.
    build(9, 4, 16'h2000, 16'h1111, 16'h0F00, 3, -1, 0);
    exp_q.push_back(est(9, 4, 16'h2000, 16'h1111, 16'h0F00, 3));
    run(1'b0, 5, 10, 47, -1);

    // Reset during ACC at cycle 20 aborts without done.
    build(9, 4, 16'h3000, 16'h2222, 16'h0055, 5, -1, 0);
    while (sched.size() > 21) void'(sched.pop_back());
    repeat (3) sched.push_back(idle_step());
    run(1'b0, -1, -1, -1, 20);

    // Fresh job after the abort.
    build(9, 4, 16'h4000, 16'h3333, 16'h0AA0, 4, -1, 0);
    exp_q.push_back(est(9, 4, 16'h4000, 16'h3333, 16'h0AA0, 4));
    run(1'b0, -1, -1, -1, -1);

    // Minimal configuration instance.
    build(1, 1, 16'h0500, 16'h0600, 16'h0001, 6, -1, 0);
    exp_q.push_back(32'hC0FF_EE01);
    run(1'b1, -1, -1, -1, -1);

    chk("sb_empty", 0, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
